// File: rtl/umich_seqgen_pkg.sv
// Shared op encoding for the UMICH generic multi-bit sequential element.
package umich_seqgen_pkg;

  typedef logic [2:0] sg_op_t;

  localparam sg_op_t SG_SCAN = 3'd0;
  localparam sg_op_t SG_HOLD = 3'd1;
  localparam sg_op_t SG_CLR  = 3'd2;
  localparam sg_op_t SG_SET  = 3'd3;
  localparam sg_op_t SG_TGL  = 3'd4;
  localparam sg_op_t SG_LOAD = 3'd5;

  // Resolve the synchronous controls into one op, highest priority first.
  function automatic sg_op_t sg_decode(input logic scan_sel, input logic en,
                                       input logic clr, input logic set,
                                       input logic tgl);
    sg_op_t op;
    op = SG_LOAD;
    if (scan_sel)  op = SG_SCAN;
    else if (!en)  op = SG_HOLD;
    else if (clr)  op = SG_CLR;
    else if (set)  op = SG_SET;
    else if (tgl)  op = SG_TGL;
    return op;
  endfunction

endpackage

// File: rtl/umich_seqgen_bit.sv
// Single storage bit: async clear/preset and a 6-way next-value mux on the shared op.
module umich_seqgen_bit
  import umich_seqgen_pkg::*;
#(
  parameter logic PRESET_BIT = 1'b1
) (
  input  logic   clocked_on,
  input  logic   preset,
  input  logic   clear,
  input  sg_op_t op,
  input  logic   d,
  input  logic   shift_in,
  output logic   q
);

  // Clear dominates preset; both are level-held over clock edges.
  always_ff @(posedge clocked_on or posedge clear or posedge preset) begin
    if (clear) begin
      q <= 1'b0;
    end else if (preset) begin
      q <= PRESET_BIT;
    end else begin
      case (op)
        SG_SCAN: q <= shift_in;
        SG_HOLD: q <= q;
        SG_CLR:  q <= 1'b0;
        SG_SET:  q <= PRESET_BIT;
        SG_TGL:  q <= ~q;
        SG_LOAD: q <= d;
        default: q <= q;
      endcase
    end
  end

endmodule

// File: rtl/umich_seqgen_vec.sv
// WIDTH-bit generic register with sync clear/preset/toggle/enable and an optional scan chain.
module umich_seqgen_vec
  import umich_seqgen_pkg::*;
#(
  parameter int unsigned      WIDTH      = 8,
  parameter logic [WIDTH-1:0] PRESET_VAL = '1,
  parameter int unsigned      SCAN_EN    = 1
) (
  input  logic             clocked_on,
  input  logic             preset,
  input  logic             clear,
  input  logic [WIDTH-1:0] next_state,
  input  logic             synch_enable,
  input  logic             synch_clear,
  input  logic             synch_preset,
  input  logic             synch_toggle,
  input  logic             scan_en,
  input  logic             scan_in,
  output logic             scan_out,
  output logic [WIDTH-1:0] Q
);

  localparam logic SCAN_PRESENT = (SCAN_EN != 0);

  sg_op_t           op;
  logic [WIDTH-1:0] shift_in;

  // One decode shared by every bit cell.
  always_comb begin
    op = sg_decode(SCAN_PRESENT & scan_en, synch_enable, synch_clear,
                   synch_preset, synch_toggle);
  end

  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    if (i == 0) begin : g_head
      assign shift_in[i] = scan_in;
    end else begin : g_link
      assign shift_in[i] = Q[i-1];
    end

    umich_seqgen_bit #(
      .PRESET_BIT (PRESET_VAL[i])
    ) u_bit (
      .clocked_on (clocked_on),
      .preset     (preset),
      .clear      (clear),
      .op         (op),
      .d          (next_state[i]),
      .shift_in   (shift_in[i]),
      .q          (Q[i])
    );
  end

  assign scan_out = SCAN_PRESENT ? Q[WIDTH-1] : 1'b0;

endmodule
